feedback_tracker: RTL

- Parametrised, multi-channel first-order feedback loop.
- Each channel keeps a signed state register. Every accepted sample updates it in one of two modes:
  - tracking: state += (in - state) >>> k
  - accumulate: state += in >>> k
- Channels are time-multiplexed through one shared datapath with a per-channel state array.
- Used as a smoothing filter or integrator ahead of downstream control logic.

---
 rtl/feedback_pkg.sv | 46 ++++
 rtl/feedback_tracker_alu.sv | 47 ++++
 rtl/feedback_tracker.sv | 114 +++++++++++
 3 files changed

// File: rtl/feedback_pkg.sv
// Shared definitions for the feedback_tracker block.
//   MODE_TRACK / MODE_ACC : encoding of the 'mode' input
//   clog2                 : ceiling log2 used to size index and shift ports
//   sat_or_wrap           : folds a wide signed result back into a WIDTH-bit
//                           range, either clamping or keeping the low bits
package feedback_pkg;

    localparam logic MODE_TRACK = 1'b0;
    localparam logic MODE_ACC   = 1'b1;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // The result is returned sign-extended to 64 bits; callers keep the low
    // 'width' bits. Width-independent so one function serves every instance.
    function automatic logic signed [63:0] sat_or_wrap(
        input logic signed [63:0] value,
        input int                 width,
        input int                 saturate
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] result;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (saturate != 0 && value > max_v) begin
            result = max_v;
        end else if (saturate != 0 && value < min_v) begin
            result = min_v;
        end else begin
            // Drop the bits above 'width' and re-extend from the new sign bit.
            result = (value <<< (64 - width)) >>> (64 - width);
        end
        return result;
    endfunction

endpackage

// File: rtl/feedback_tracker_alu.sv
// Combinational update datapath shared by all channels.
//   i_state : current signed state of the selected channel
//   i_data  : signed sample
//   i_mode  : MODE_TRACK (move toward sample) or MODE_ACC (integrate sample)
//   i_k     : gain exponent, clamped to MAX_SHIFT
//   o_r     : unbounded next state at WIDTH+2 bits
//   o_ovf   : o_r does not fit in the signed WIDTH range
module feedback_tracker_alu
    import feedback_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_SHIFT = 7,
    parameter int KW        = 3
) (
    input  logic signed [WIDTH-1:0] i_state,
    input  logic signed [WIDTH-1:0] i_data,
    input  logic                    i_mode,
    input  logic [KW-1:0]           i_k,
    output logic signed [WIDTH+1:0] o_r,
    output logic                    o_ovf
);

    logic signed [WIDTH:0] w_s_ext;
    logic signed [WIDTH:0] w_d_ext;
    logic signed [WIDTH:0] w_e;
    logic signed [WIDTH:0] w_d;
    logic [KW-1:0]         w_k;

    assign w_s_ext = {i_state[WIDTH-1], i_state};
    assign w_d_ext = {i_data[WIDTH-1], i_data};

    // A WIDTH+1 bit difference of two WIDTH-bit values cannot overflow.
    assign w_e = (i_mode == MODE_ACC) ? w_d_ext : (w_d_ext - w_s_ext);

    assign w_k = (int'(i_k) > MAX_SHIFT) ? KW'(MAX_SHIFT) : i_k;

    // Arithmetic shift floors toward -inf, so -1 >>> k stays -1.
    assign w_d = w_e >>> w_k;

    assign o_r = {w_s_ext[WIDTH], w_s_ext} + {w_d[WIDTH], w_d};

    // The top three bits must agree for the value to fit in WIDTH bits.
    // Used for both modes; tracking results simply never trip it.
    assign o_ovf = (o_r[WIDTH+1:WIDTH-1] != 3'b000) &&
                   (o_r[WIDTH+1:WIDTH-1] != 3'b111);

endmodule

// File: rtl/feedback_tracker.sv
// Multi-channel first-order feedback loop (smoother / integrator).
//   system1000, system1000_rstn : clock, async active-low reset
//   in_valid, in_ch, in_data    : sample strobe, channel, signed sample
//   mode, k_shift               : update mode and gain exponent per sample
//   clear                       : zero every channel state (wins over in_valid)
//   ovf_clr                     : zero the sticky overflow flags
//   out_valid, out_ch, out_data : one-cycle result strobe, channel, new state
//   ovf                         : sticky per-channel overflow flags
//
// Handshake: there is no ready. A sample is taken on any rising edge where
// in_valid=1, clear=0 and in_ch < CHANNELS; the matching result appears with
// out_valid=1 for exactly one cycle after that edge. out_ch/out_data hold
// their last values whenever out_valid=0.
module feedback_tracker
    import feedback_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 1,
    parameter int MAX_SHIFT = 7,
    parameter int SATURATE  = 1,
    localparam int CW = (CHANNELS > 1) ? clog2(CHANNELS) : 1,
    localparam int KW = (MAX_SHIFT > 0) ? clog2(MAX_SHIFT + 1) : 1
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    in_valid,
    input  logic [CW-1:0]           in_ch,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    mode,
    input  logic [KW-1:0]           k_shift,
    input  logic                    clear,
    input  logic                    ovf_clr,
    output logic                    out_valid,
    output logic [CW-1:0]           out_ch,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]     ovf
);

    logic signed [WIDTH-1:0] r_state [CHANNELS];

    logic                    w_in_range;
    logic                    w_accept;
    logic [CW-1:0]           w_idx;
    logic signed [WIDTH-1:0] w_s;
    logic signed [WIDTH+1:0] w_r;
    logic                    w_ovf;
    logic signed [WIDTH-1:0] w_new;
    logic [CHANNELS-1:0]     w_ovf_set;

    assign w_in_range = (int'(in_ch) < CHANNELS);
    assign w_accept   = in_valid && w_in_range && !clear;

    // Out-of-range indices never reach the array.
    assign w_idx = w_in_range ? in_ch : '0;

    // Read straight from the array so a sample right after a write to the
    // same channel sees the new value.
    assign w_s = r_state[w_idx];

    feedback_tracker_alu #(
        .WIDTH     (WIDTH),
        .MAX_SHIFT (MAX_SHIFT),
        .KW        (KW)
    ) u_alu (
        .i_state (w_s),
        .i_data  (in_data),
        .i_mode  (mode),
        .i_k     (k_shift),
        .o_r     (w_r),
        .o_ovf   (w_ovf)
    );

    assign w_new = WIDTH'(sat_or_wrap(64'(w_r), WIDTH, SATURATE));

    always_comb begin
        w_ovf_set = '0;
        if (w_accept && w_ovf) begin
            w_ovf_set[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= '0;
            end
            out_valid <= 1'b0;
        end else if (w_accept) begin
            r_state[w_idx] <= w_new;
            out_valid      <= 1'b1;
            out_ch         <= in_ch;
            out_data       <= w_new;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // A new overflow outranks ovf_clr on its own channel.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf_clr ? '0 : ovf) | w_ovf_set;
        end
    end

endmodule
